// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic-array operand feed blocks.
// Holds default RAM geometry and the operand-reader FSM state type.
package systolic_pkg;

   localparam int unsigned DefOutputWidth  = 16;
   localparam int unsigned DefAddressWidth = 4;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StRead  = 2'd1,
      StDrain = 2'd2
   } rd_state_e;

endpackage

// File: rtl/ram_stream_reader.sv
// Sweeps a window of an external 1-cycle-latency operand RAM and presents the
// words as a valid/ready stream. The RAM output register doubles as the stream buffer.
module ram_stream_reader
   import systolic_pkg::*;
#(
   parameter int unsigned Output_width  = DefOutputWidth,
   parameter int unsigned Address_width = DefAddressWidth,
   parameter int unsigned BASE_ADDR     = 0,
   parameter int unsigned NUM_WORDS     = 10
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic                     ready,
   output logic                     ram_en,
   output logic                     ram_we,
   output logic [Address_width-1:0] ram_addr,
   input  logic [Output_width-1:0]  ram_do,
   output logic [Output_width-1:0]  data_out,
   output logic                     data_valid,
   output logic                     data_last,
   output logic                     busy,
   output logic                     done
);

   localparam int unsigned CntW = Address_width + 1;
   localparam logic [Address_width-1:0] BaseAddr = Address_width'(BASE_ADDR);
   localparam logic [CntW-1:0]          LastIdx  = CntW'(NUM_WORDS - 1);

   rd_state_e               state_q, state_d;
   logic [Address_width-1:0] addr_q, addr_d;
   logic [CntW-1:0]          count_q, count_d;
   logic                     valid_q, valid_d;
   logic                     done_q, done_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         addr_q  <= BaseAddr;
         count_q <= '0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         count_q <= count_d;
         valid_q <= valid_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      count_d = count_q;
      done_d  = 1'b0;
      ram_en  = 1'b0;

      unique case (state_q)
         StIdle: begin
            // A start coinciding with the done pulse is dropped.
            if (start && !done_q) begin
               state_d = StRead;
               addr_d  = BaseAddr;
               count_d = '0;
            end
         end
         StRead: begin
            // Fetch only when the word held in the RAM output is consumed or absent.
            ram_en = ready | ~valid_q;
            if (ram_en) begin
               addr_d  = addr_q + Address_width'(1);
               count_d = count_q + CntW'(1);
               if (count_q == LastIdx) begin
                  state_d = StDrain;
               end
            end
         end
         StDrain: begin
            if (valid_q && ready) begin
               state_d = StIdle;
               done_d  = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase

      valid_d = valid_q;
      if (ram_en) begin
         valid_d = 1'b1;
      end else if (ready) begin
         valid_d = 1'b0;
      end
   end

   // In DRAIN the only word that can still be pending is the final one.
   assign data_last  = valid_q && (state_q == StDrain);
   assign ram_we     = 1'b0;
   assign ram_addr   = addr_q;
   assign data_out   = ram_do;
   assign data_valid = valid_q;
   assign busy       = (state_q != StIdle);
   assign done       = done_q;

endmodule

// File: tb/tb_ram_stream_reader.sv
// Directed bench for ram_stream_reader with three parameterisations sharing one
// behavioural operand RAM image.
module tb_ram_stream_reader;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        start0, ready0, ram_en0, ram_we0, valid0, last0, busy0, done0;
   logic [3:0]  addr0;
   logic [15:0] ram_do0, data0;
   logic        start1, ready1, ram_en1, ram_we1, valid1, last1, busy1, done1;
   logic [3:0]  addr1;
   logic [15:0] ram_do1, data1;
   logic        start2, ready2, ram_en2, ram_we2, valid2, last2, busy2, done2;
   logic [3:0]  addr2;
   logic [15:0] ram_do2, data2;

   int checks = 0;
   int errors = 0;

   logic [15:0] mem [16];
   logic [15:0] exp_words [10];
   logic [15:0] exp_wrap [4];
   logic [3:0]  exp_addr [4];

   always @(posedge clk) if (ram_en0) ram_do0 <= mem[addr0];
   always @(posedge clk) if (ram_en1) ram_do1 <= mem[addr1];
   always @(posedge clk) if (ram_en2) ram_do2 <= mem[addr2];

   ram_stream_reader #(.Output_width(16), .Address_width(4), .BASE_ADDR(0), .NUM_WORDS(10)) u_dut0 (
      .clk(clk), .rst(rst), .start(start0), .ready(ready0), .ram_en(ram_en0), .ram_we(ram_we0),
      .ram_addr(addr0), .ram_do(ram_do0), .data_out(data0), .data_valid(valid0),
      .data_last(last0), .busy(busy0), .done(done0)
   );

   ram_stream_reader #(.Output_width(16), .Address_width(4), .BASE_ADDR(14), .NUM_WORDS(4)) u_dut1 (
      .clk(clk), .rst(rst), .start(start1), .ready(ready1), .ram_en(ram_en1), .ram_we(ram_we1),
      .ram_addr(addr1), .ram_do(ram_do1), .data_out(data1), .data_valid(valid1),
      .data_last(last1), .busy(busy1), .done(done1)
   );

   ram_stream_reader #(.Output_width(16), .Address_width(4), .BASE_ADDR(0), .NUM_WORDS(1)) u_dut2 (
      .clk(clk), .rst(rst), .start(start2), .ready(ready2), .ram_en(ram_en2), .ram_we(ram_we2),
      .ram_addr(addr2), .ram_do(ram_do2), .data_out(data2), .data_valid(valid2),
      .data_last(last2), .busy(busy2), .done(done2)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Full 10-word sweep on dut0, optionally stalling on word index 3 and
   // re-pulsing start while busy and on the done cycle.
   task automatic sweep0(input string tag, input bit do_stall, input bit do_repulse);
      int n, stalls, last_c, done_c;
      bit got_done;
      n = 0; stalls = 0; last_c = -10; done_c = -1; got_done = 1'b0;
      @(negedge clk); start0 = 1'b1; ready0 = 1'b1;
      @(negedge clk); start0 = 1'b0;
      chk({tag, "_busy"}, busy0, 1);
      chk({tag, "_lat_valid"}, valid0, 0);
      chk({tag, "_first_en"}, ram_en0, 1);
      for (int c = 0; c < 40 && !got_done; c++) begin
         @(negedge clk);
         start0 = do_repulse && (c == 3);
         if (do_stall && valid0 && n == 3 && stalls < 3) begin
            ready0 = 1'b0; stalls++; #1;
            chk({tag, "_stall_data"}, data0, exp_words[3]);
            chk({tag, "_stall_en"}, ram_en0, 0);
            chk({tag, "_stall_valid"}, valid0, 1);
         end else begin
            ready0 = 1'b1; #1;
            if (done0) begin
               got_done = 1'b1; done_c = c;
               chk({tag, "_done_busy"}, busy0, 0);
               chk({tag, "_done_valid"}, valid0, 0);
               start0 = do_repulse;
            end else if (valid0) begin
               if (n == 0) chk({tag, "_first_cycle"}, c, 0);
               if (n < 10) chk({tag, "_data"}, data0, exp_words[n]);
               chk({tag, "_last"}, last0, (n == 9));
               chk({tag, "_we"}, ram_we0, 0);
               if (n == 9) last_c = c;
               n++;
            end
         end
      end
      chk({tag, "_nwords"}, n, 10);
      chk({tag, "_got_done"}, got_done, 1);
      chk({tag, "_done_timing"}, done_c, last_c + 1);
      if (do_stall) chk({tag, "_stalls"}, stalls, 3);
      @(negedge clk); start0 = 1'b0;
      chk({tag, "_done_pulse"}, done0, 0);
      chk({tag, "_idle_busy"}, busy0, 0);
      repeat (3) @(negedge clk);
      chk({tag, "_idle_valid"}, valid0, 0);
      chk({tag, "_idle_busy2"}, busy0, 0);
   endtask

   initial begin
      int n, ni;
      bit got;

      for (int i = 0; i < 16; i++) mem[i] = 16'd0;
      exp_words = '{16'd0, 16'd1, 16'd4, 16'd7, 16'd2, 16'd5, 16'd8, 16'd3, 16'd6, 16'd9};
      for (int i = 0; i < 10; i++) mem[i] = exp_words[i];
      exp_wrap = '{16'd0, 16'd0, 16'd0, 16'd1};
      exp_addr = '{4'd14, 4'd15, 4'd0, 4'd1};

      rst = 1'b1;
      start0 = 1'b0; ready0 = 1'b0;
      start1 = 1'b0; ready1 = 1'b0;
      start2 = 1'b0; ready2 = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_valid", valid0, 0);
      chk("rst_busy", busy0, 0);
      chk("rst_done", done0, 0);
      chk("rst_last", last0, 0);
      chk("rst_en", ram_en0, 0);
      chk("rst_we", ram_we0, 0);
      chk("rst_addr0", addr0, 0);
      chk("rst_addr1", addr1, 14);
      rst = 1'b0;

      sweep0("t1_free", 1'b0, 1'b0);
      sweep0("t2_stall", 1'b1, 1'b0);

      // Wrap window on dut1.
      n = 0; ni = 0; got = 1'b0;
      @(negedge clk); start1 = 1'b1; ready1 = 1'b1;
      for (int c = 0; c < 20 && !got; c++) begin
         @(negedge clk); start1 = 1'b0;
         if (ram_en1) begin
            if (ni < 4) chk("t3_addr", addr1, exp_addr[ni]);
            ni++;
         end
         if (done1) got = 1'b1;
         else if (valid1) begin
            if (n < 4) chk("t3_data", data1, exp_wrap[n]);
            chk("t3_last", last1, (n == 3));
            n++;
         end
      end
      chk("t3_issues", ni, 4);
      chk("t3_nwords", n, 4);
      chk("t3_done", got, 1);

      sweep0("t4_busy_start", 1'b0, 1'b1);

      // Reset in the middle of a sweep.
      n = 0;
      @(negedge clk); start0 = 1'b1; ready0 = 1'b1;
      @(negedge clk); start0 = 1'b0;
      for (int c = 0; c < 20 && n < 5; c++) begin
         @(negedge clk);
         if (valid0) n++;
      end
      chk("t5_pre_words", n, 5);
      @(posedge clk); #2;
      chk("t5_pre_valid", valid0, 1);
      rst = 1'b1; #1;
      chk("t5_rst_valid", valid0, 0);
      chk("t5_rst_busy", busy0, 0);
      chk("t5_rst_done", done0, 0);
      chk("t5_rst_en", ram_en0, 0);
      chk("t5_rst_addr", addr0, 0);
      @(negedge clk); rst = 1'b0;
      sweep0("t5_restart", 1'b0, 1'b0);

      // Single-word sweep on dut2.
      n = 0; got = 1'b0;
      @(negedge clk); start2 = 1'b1; ready2 = 1'b1;
      @(negedge clk); start2 = 1'b0;
      chk("t6_busy", busy2, 1);
      for (int c = 0; c < 10 && !got; c++) begin
         @(negedge clk);
         if (done2) got = 1'b1;
         else if (valid2) begin
            chk("t6_data", data2, 0);
            chk("t6_last", last2, 1);
            n++;
         end
      end
      chk("t6_nwords", n, 1);
      chk("t6_done", got, 1);
      @(negedge clk);
      chk("t6_idle", busy2, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
